// File: rtl/spi_ctrl_pkg.sv
// Shared types and default timing constants for the SPI transfer controller.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLoad,
    StXfer,
    StHold
  } spi_xfer_state_t;

  localparam int unsigned DefCsSetupCycles = 4;
  localparam int unsigned DefCsHoldCycles  = 4;
  localparam int unsigned DefTimeoutCycles = 1024;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Request, tx/rx byte streams, byte-engine and status signals of spi_xfer_ctrl.
interface spi_xfer_ctrl_if #(
  parameter int unsigned LenWidth = 8
) ();

  logic                req_valid_i;
  logic                req_ready_o;
  logic [LenWidth-1:0] req_len_i;
  logic                tx_valid_i;
  logic                tx_ready_o;
  logic [7:0]          tx_data_i;
  logic                rx_valid_o;
  logic [7:0]          rx_data_o;
  logic                spi_start_o;
  logic [7:0]          spi_byte_o;
  logic [7:0]          spi_byte_i;
  logic                spi_next_i;
  logic                cs_no;
  logic                busy_o;
  logic                done_o;
  logic                error_o;

  modport slave (
    input  req_valid_i, req_len_i, tx_valid_i, tx_data_i, spi_byte_i, spi_next_i,
    output req_ready_o, tx_ready_o, rx_valid_o, rx_data_o, spi_start_o, spi_byte_o,
           cs_no, busy_o, done_o, error_o
  );

  modport master (
    output req_valid_i, req_len_i, tx_valid_i, tx_data_i, spi_byte_i, spi_next_i,
    input  req_ready_o, tx_ready_o, rx_valid_o, rx_data_o, spi_start_o, spi_byte_o,
           cs_no, busy_o, done_o, error_o
  );

endinterface

// File: rtl/spi_cs_timer.sv
// Loadable down-counter with zero flag; times both CS setup and CS hold.
module spi_cs_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI transaction sequencer: CS setup, per-byte handoff to a byte engine, CS hold.
// Optional per-byte watchdog enabled by defining SPI_XFER_CTRL_TIMEOUT_EN.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned CsSetupCycles = DefCsSetupCycles,
  parameter int unsigned CsHoldCycles  = DefCsHoldCycles,
  parameter int unsigned LenWidth      = 8,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input logic             clk_i,
  input logic             rst_ni,
  spi_xfer_ctrl_if.slave  bus
);

  localparam int unsigned TimerMax   = (CsSetupCycles > CsHoldCycles) ? CsSetupCycles
                                                                      : CsHoldCycles;
  localparam int unsigned TimerWidth = (TimerMax > 1) ? $clog2(TimerMax) : 1;
  // The timer is loaded with N-1 so the state lasts N cycles (minimum one).
  localparam logic [TimerWidth-1:0] SetupLoad =
      (CsSetupCycles > 0) ? TimerWidth'(CsSetupCycles - 1) : '0;
  localparam logic [TimerWidth-1:0] HoldLoad =
      (CsHoldCycles > 0) ? TimerWidth'(CsHoldCycles - 1) : '0;

  spi_xfer_state_t     state_q, state_d;
  logic [LenWidth-1:0] rem_q, rem_d;
  logic                cs_n_q, cs_n_d;
  logic                start_q, start_d;
  logic [7:0]          byte_q, byte_d;
  logic                rx_valid_q, rx_valid_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                next_q;
  logic                next_rise;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic [TimerWidth-1:0] tmr_val;
  logic                wd_expired;

  assign next_rise = bus.spi_next_i & ~next_q;

  spi_cs_timer #(
    .Width (TimerWidth)
  ) u_cs_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

`ifdef SPI_XFER_CTRL_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(TimeoutCycles + 1);
  logic [WdWidth-1:0] wd_q, wd_d;

  assign wd_expired = (state_q == StXfer) && (wd_q == WdWidth'(TimeoutCycles - 1));

  always_comb begin
    wd_d = wd_q;
    if (state_q == StLoad) begin
      wd_d = '0;
    end else if ((state_q == StXfer) && !wd_expired) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cs_n_d     = cs_n_q;
    start_d    = start_q;
    byte_d     = byte_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = SetupLoad;
    tmr_dec    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid_i) begin
          rem_d    = bus.req_len_i;
          cs_n_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = SetupLoad;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        if (tmr_zero) begin
          state_d = StLoad;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StLoad: begin
        if (bus.tx_valid_i) begin
          byte_d  = bus.tx_data_i;
          start_d = 1'b1;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (next_rise) begin
          start_d    = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = bus.spi_byte_i;
          if (rem_q == '0) begin
            tmr_load = 1'b1;
            tmr_val  = HoldLoad;
            state_d  = StHold;
          end else begin
            rem_d   = rem_q - 1'b1;
            state_d = StLoad;
          end
        end else if (wd_expired) begin
          start_d  = 1'b0;
          error_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = HoldLoad;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (tmr_zero) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      cs_n_q     <= 1'b1;
      start_q    <= 1'b0;
      byte_q     <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      next_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cs_n_q     <= cs_n_d;
      start_q    <= start_d;
      byte_q     <= byte_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      next_q     <= bus.spi_next_i;
    end
  end

  assign bus.req_ready_o = (state_q == StIdle);
  assign bus.tx_ready_o  = (state_q == StLoad);
  assign bus.busy_o      = (state_q != StIdle);
  // Start drops combinationally in the completion cycle so the engine never sees a re-issue.
  assign bus.spi_start_o = start_q & ~next_rise;
  assign bus.spi_byte_o  = byte_q;
  assign bus.rx_valid_o  = rx_valid_q;
  assign bus.rx_data_o   = rx_data_q;
  assign bus.cs_no       = cs_n_q;
  assign bus.done_o      = done_q;
  assign bus.error_o     = error_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed self-checking bench for spi_xfer_ctrl with a behavioural byte engine and tx source.
module tb_spi_xfer_ctrl;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_ctrl_if #(.LenWidth(8)) bus ();

  spi_xfer_ctrl #(
    .CsSetupCycles (4),
    .CsHoldCycles  (4),
    .LenWidth      (8),
    .TimeoutCycles (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] tx_src[$];
  logic [7:0] eng_resp[$];
  logic [7:0] rx_log[$];
  logic [7:0] byte_log[$];
  int done_cnt, err_cnt, cs_rise_cnt;
  bit start_prev, cs_prev;
  int eng_delay = 2;
  int eng_hold  = 1;
  bit eng_en    = 1'b1;
  bit eng_busy  = 1'b0;
  int tx_gap_idx = -1;
  int tx_gap_len = 0;
  int tx_sent    = 0;
  bit last_ready = 1'b0;

  // Byte engine: answers each start level after eng_delay cycles with a spi_next_i level.
  initial begin
    bus.spi_next_i = 1'b0;
    bus.spi_byte_i = 8'h00;
    forever begin
      @(negedge clk);
      if (eng_en && bus.spi_start_o === 1'b1) begin
        eng_busy = 1'b1;
        repeat (eng_delay) @(negedge clk);
        bus.spi_byte_i = (eng_resp.size() > 0) ? eng_resp.pop_front() : 8'h00;
        bus.spi_next_i = 1'b1;
        repeat (eng_hold) @(negedge clk);
        bus.spi_next_i = 1'b0;
        eng_busy = 1'b0;
      end
    end
  end

  // Tx source: offers tx_src in order, withholding tx_gap_len ready cycles before byte tx_gap_idx.
  initial begin
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.tx_valid_i && last_ready && tx_src.size() > 0) begin
        tx_src.delete(0);
        tx_sent++;
      end
      last_ready = bus.tx_ready_o;
      if (tx_src.size() > 0 && tx_sent == tx_gap_idx && tx_gap_len > 0) begin
        bus.tx_valid_i = 1'b0;
        if (bus.tx_ready_o) tx_gap_len--;
      end else if (tx_src.size() > 0) begin
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = tx_src[0];
      end else begin
        bus.tx_valid_i = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.rx_valid_o) rx_log.push_back(bus.rx_data_o);
    if (bus.done_o) done_cnt++;
    if (bus.error_o) err_cnt++;
    if (bus.spi_start_o && !start_prev) byte_log.push_back(bus.spi_byte_o);
    start_prev = bus.spi_start_o;
    if (bus.cs_no && !cs_prev) cs_rise_cnt++;
    cs_prev = bus.cs_no;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish, failed=%0d", fails);
    $fatal(1);
  end

  task automatic clear_logs();
    rx_log.delete();
    byte_log.delete();
    eng_resp.delete();
    tx_src.delete();
    done_cnt = 0;
    err_cnt = 0;
    cs_rise_cnt = 0;
    tx_sent = 0;
    tx_gap_idx = -1;
    tx_gap_len = 0;
  endtask

  task automatic send_req(input logic [7:0] len);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_len_i   = len;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req_valid_i = 1'b0;
    bus.req_len_i   = 8'h00;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.cs_no !== 1'b1) begin fails++; $display("FAIL rst_cs got %b want 1", bus.cs_no); end
    tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", bus.busy_o); end
    tests++; if (bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL rst_req_ready got %b want 1", bus.req_ready_o); end
    tests++; if (bus.tx_ready_o !== 1'b0) begin fails++; $display("FAIL rst_tx_ready got %b want 0", bus.tx_ready_o); end
    tests++; if (bus.spi_start_o !== 1'b0) begin fails++; $display("FAIL rst_start got %b want 0", bus.spi_start_o); end
    tests++; if (bus.spi_byte_o !== 8'h00) begin fails++; $display("FAIL rst_byte got %h want 00", bus.spi_byte_o); end
    tests++; if (bus.rx_valid_o !== 1'b0) begin fails++; $display("FAIL rst_rx_valid got %b want 0", bus.rx_valid_o); end
    tests++; if (bus.rx_data_o !== 8'h00) begin fails++; $display("FAIL rst_rx_data got %h want 00", bus.rx_data_o); end
    tests++; if (bus.done_o !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", bus.done_o); end
    tests++; if (bus.error_o !== 1'b0) begin fails++; $display("FAIL rst_error got %b want 0", bus.error_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int setup_cnt, hold_cnt;
    bit seen, ok, got_done;
    clear_logs();
    tx_src.push_back(8'hA5);
    eng_resp.push_back(8'h3C);
    send_req(8'd0);
    setup_cnt = 0;
    for (int i = 0; i < 50 && !bus.tx_ready_o; i++) begin
      if (bus.cs_no === 1'b0) setup_cnt++;
      @(negedge clk);
    end
    tests++; if (setup_cnt != 4) begin fails++; $display("FAIL single_setup got %0d want 4", setup_cnt); end
    hold_cnt = 0; seen = 1'b0; got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rx_valid_o) seen = 1'b1;
      if (seen) begin
        if (bus.cs_no) begin
          got_done = bus.done_o;
          break;
        end
        hold_cnt++;
      end
    end
    tests++; if (hold_cnt != 4) begin fails++; $display("FAIL single_hold got %0d want 4", hold_cnt); end
    tests++; if (got_done !== 1'b1) begin fails++; $display("FAIL single_done_with_cs got %b want 1", got_done); end
    wait_done(20, ok);
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL single_done_cnt got %0d want 1", done_cnt); end
    tests++;
    if (rx_log.size() != 1 || rx_log[0] !== 8'h3C) begin
      fails++; $display("FAIL single_rx got n=%0d d=%h want n=1 d=3c", rx_log.size(),
                        (rx_log.size() > 0) ? rx_log[0] : 8'hxx);
    end
    tests++;
    if (byte_log.size() != 1 || byte_log[0] !== 8'hA5) begin
      fails++; $display("FAIL single_tx got n=%0d want n=1 d=a5", byte_log.size());
    end
    tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL single_idle_busy got %b want 0", bus.busy_o); end
  endtask

  task automatic test_three_byte();
    bit ok;
    logic [7:0] exp_tx[3];
    logic [7:0] exp_rx[3];
    exp_tx = '{8'h01, 8'h02, 8'h03};
    exp_rx = '{8'h11, 8'h22, 8'h33};
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      tx_src.push_back(exp_tx[i]);
      eng_resp.push_back(exp_rx[i]);
    end
    send_req(8'd2);
    wait_done(300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL three_done_timeout got 0 want 1"); end
    tests++; if (byte_log.size() != 3) begin fails++; $display("FAIL three_tx_cnt got %0d want 3", byte_log.size()); end
    tests++; if (rx_log.size() != 3) begin fails++; $display("FAIL three_rx_cnt got %0d want 3", rx_log.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < byte_log.size()) begin
        tests++;
        if (byte_log[i] !== exp_tx[i]) begin
          fails++; $display("FAIL three_tx[%0d] got %h want %h", i, byte_log[i], exp_tx[i]);
        end
      end
      if (i < rx_log.size()) begin
        tests++;
        if (rx_log[i] !== exp_rx[i]) begin
          fails++; $display("FAIL three_rx[%0d] got %h want %h", i, rx_log[i], exp_rx[i]);
        end
      end
    end
    tests++; if (cs_rise_cnt != 1) begin fails++; $display("FAIL three_cs_rises got %0d want 1", cs_rise_cnt); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL three_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_tx_underflow();
    bit ok, found;
    int bad;
    clear_logs();
    tx_src = '{8'h41, 8'h42, 8'h43};
    eng_resp = '{8'h51, 8'h52, 8'h53};
    tx_gap_idx = 1;
    tx_gap_len = 20;
    send_req(8'd2);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (byte_log.size() == 1 && bus.tx_ready_o) begin
        found = 1'b1;
        break;
      end
    end
    tests++; if (!found) begin fails++; $display("FAIL underflow_reach_load got 0 want 1"); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_ready_o !== 1'b1 || bus.cs_no !== 1'b0 || bus.spi_start_o !== 1'b0) bad++;
      if (i < 19) @(negedge clk);
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL underflow_stall got %0d bad cycles want 0", bad); end
    wait_done(300, ok);
    tests++; if (byte_log.size() != 3 || rx_log.size() != 3) begin
      fails++; $display("FAIL underflow_counts got tx=%0d rx=%0d want 3/3", byte_log.size(), rx_log.size());
    end
    tests++; if (cs_rise_cnt != 1) begin fails++; $display("FAIL underflow_cs_rises got %0d want 1", cs_rise_cnt); end
  endtask

  task automatic test_long_next();
    bit ok;
    clear_logs();
    tx_src = '{8'hAA, 8'hBB};
    eng_resp = '{8'h5A, 8'h6B};
    eng_hold = 6;
    send_req(8'd1);
    wait_done(300, ok);
    eng_hold = 1;
    tests++; if (!ok) begin fails++; $display("FAIL long_done_timeout got 0 want 1"); end
    tests++; if (rx_log.size() != 2) begin fails++; $display("FAIL long_rx_cnt got %0d want 2", rx_log.size()); end
    tests++;
    if (rx_log.size() < 2 || rx_log[0] !== 8'h5A || rx_log[1] !== 8'h6B) begin
      fails++; $display("FAIL long_rx_data got n=%0d want 5a,6b", rx_log.size());
    end
    tests++; if (byte_log.size() != 2) begin fails++; $display("FAIL long_tx_cnt got %0d want 2", byte_log.size()); end
  endtask

  task automatic test_max_len();
    bit ok;
    clear_logs();
    eng_delay = 1;
    for (int i = 0; i < 256; i++) begin
      tx_src.push_back(8'(i));
      eng_resp.push_back(8'(255 - i));
    end
    send_req(8'hFF);
    wait_done(4000, ok);
    eng_delay = 2;
    tests++; if (!ok) begin fails++; $display("FAIL max_done_timeout got 0 want 1"); end
    tests++; if (byte_log.size() != 256) begin fails++; $display("FAIL max_tx_cnt got %0d want 256", byte_log.size()); end
    tests++; if (rx_log.size() != 256) begin fails++; $display("FAIL max_rx_cnt got %0d want 256", rx_log.size()); end
    tests++;
    if (rx_log.size() == 256 && (rx_log[255] !== 8'h00 || byte_log[255] !== 8'hFF)) begin
      fails++; $display("FAIL max_last got rx=%h tx=%h want 00/ff", rx_log[255], byte_log[255]);
    end
    tests++; if (cs_rise_cnt != 1) begin fails++; $display("FAIL max_cs_rises got %0d want 1", cs_rise_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    clear_logs();
    tx_src = '{8'h10, 8'h20, 8'h30, 8'h40};
    eng_resp = '{8'h90, 8'hA0, 8'hB0, 8'hC0};
    eng_delay = 8;
    send_req(8'd3);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (byte_log.size() >= 2) begin
        found = 1'b1;
        break;
      end
    end
    tests++; if (!found) begin fails++; $display("FAIL mid_reach_byte2 got 0 want 1"); end
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    tests++; if (bus.cs_no !== 1'b1) begin fails++; $display("FAIL mid_cs got %b want 1", bus.cs_no); end
    tests++; if (bus.spi_start_o !== 1'b0) begin fails++; $display("FAIL mid_start got %b want 0", bus.spi_start_o); end
    tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL mid_busy got %b want 0", bus.busy_o); end
    tx_src.delete();
    for (int i = 0; i < 50 && eng_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    tests++; if (done_cnt != 0) begin fails++; $display("FAIL mid_no_done got %0d want 0", done_cnt); end
    clear_logs();
    eng_delay = 2;
    tx_src.push_back(8'h77);
    eng_resp.push_back(8'h99);
    @(negedge clk);
    rst_ni = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_len_i   = 8'd0;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    tests++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL mid_first_accept got %b want 1", bus.busy_o); end
    wait_done(200, ok);
    tests++;
    if (!ok || rx_log.size() != 1 || rx_log[0] !== 8'h99) begin
      fails++; $display("FAIL mid_next_xfer got done=%0d rx_n=%0d want 1/1 d=99", done_cnt, rx_log.size());
    end
  endtask

`ifdef SPI_XFER_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int to_cnt, hold_cnt;
    bit found, got_done, ok;
    clear_logs();
    eng_en = 1'b0;
    tx_src.push_back(8'h5E);
    send_req(8'd0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.spi_start_o) begin
        found = 1'b1;
        break;
      end
    end
    tests++; if (!found) begin fails++; $display("FAIL to_issue got 0 want 1"); end
    to_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      to_cnt++;
      if (bus.error_o) break;
    end
    tests++; if (to_cnt != 16) begin fails++; $display("FAIL to_latency got %0d want 16", to_cnt); end
    tests++; if (bus.spi_start_o !== 1'b0) begin fails++; $display("FAIL to_start got %b want 0", bus.spi_start_o); end
    hold_cnt = 1; got_done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cs_no) begin
        got_done = bus.done_o;
        break;
      end
      hold_cnt++;
    end
    tests++; if (hold_cnt != 4) begin fails++; $display("FAIL to_hold got %0d want 4", hold_cnt); end
    tests++; if (got_done !== 1'b1) begin fails++; $display("FAIL to_done got %b want 1", got_done); end
    wait_done(10, ok);
    tests++; if (err_cnt != 1 || done_cnt != 1) begin
      fails++; $display("FAIL to_counts got err=%0d done=%0d want 1/1", err_cnt, done_cnt);
    end
    eng_en = 1'b1;
  endtask
`endif

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_len_i   = 8'h00;
    test_reset();
    test_single_byte();
    test_three_byte();
    test_tx_underflow();
    test_long_next();
    test_max_len();
    test_reset_mid();
`ifdef SPI_XFER_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
